// File: rtl/ram_fill_scan_pkg.sv
// Shared definitions for the ram_fill_scan block.
// Holds the default word/address widths and scan spacing, the command
// opcode encodings presented on cmd_op, and the controller state encodings.
package ram_fill_scan_pkg;

  localparam int DEFAULT_DATA_W      = 4;
  localparam int DEFAULT_ADDR_W      = 5;
  localparam int DEFAULT_SCAN_PERIOD = 4;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_FILL  = 2'b10,
    OP_SCAN  = 2'b11
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RD_WAIT   = 3'd1,
    ST_FILL      = 3'd2,
    ST_SCAN_RD   = 3'd3,
    ST_SCAN_WAIT = 3'd4
  } state_e;

endpackage

// File: rtl/ram_fill_scan_ram_sp.sv
// ram_sp: parametrised single-port RAM, synchronous write, registered read.
// Ports:
//   clock - write/read clock
//   we    - write enable, mem[addr] <= wdata on the rising edge
//   addr  - shared read/write address
//   wdata - write data
//   rdata - registered read data, mem[addr] as it was before this edge
// Contents are deliberately never reset so they survive a block reset.
module ram_sp
  import ram_fill_scan_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Both updates are non-blocking, so a read of the address being written
  // in the same cycle returns the old word.
  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ram_fill_scan.sv
// ram_fill_scan: command-driven controller around a single-port RAM.
// Commands (cmd_op): READ one word, WRITE one word, FILL every address with
// cmd_data, SCAN every address out on rd_* at a fixed spacing.
// Ports:
//   clock, reset            - clock, asynchronous active-high reset
//   cmd_valid/cmd_ready     - command handshake (cmd_ready is combinational)
//   cmd_op/cmd_addr/cmd_data- command fields
//   abort                   - stops an active FILL or SCAN
//   rd_valid/rd_addr/rd_data- registered read return, one-cycle pulse
//   busy                    - controller not idle
//   done                    - one-cycle completion pulse (never on abort)
module ram_fill_scan
  import ram_fill_scan_pkg::*;
#(
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int ADDR_W      = DEFAULT_ADDR_W,
  parameter int SCAN_PERIOD = DEFAULT_SCAN_PERIOD
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic              abort,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done
);

  // The wait timer counts 0..SCAN_PERIOD-2 between two scan outputs.
  localparam int TIMER_W = (SCAN_PERIOD > 2) ? $clog2(SCAN_PERIOD - 1) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(SCAN_PERIOD - 2);
  localparam logic [ADDR_W-1:0]  LAST_ADDR  = {ADDR_W{1'b1}};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [DATA_W-1:0] fill_data_q, fill_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              accept;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  assign cmd_ready = (state_q == ST_IDLE) && !abort;
  assign accept    = cmd_valid && cmd_ready;

  ram_sp #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clock(clock),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  // Next-state and RAM port control. The RAM read for a returned word is
  // always issued one edge before the word is registered onto rd_*, so a
  // READ or the first SCAN word is issued on the accept edge itself.
  // cnt holds the READ address while in RD_WAIT, otherwise the sweep index.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    timer_d     = timer_q;
    fill_data_d = fill_data_q;
    rd_valid_d  = 1'b0;
    rd_addr_d   = rd_addr_q;
    rd_data_d   = rd_data_q;
    done_d      = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = cmd_addr;
    ram_wdata   = cmd_data;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_READ: begin
              cnt_d   = cmd_addr;
              state_d = ST_RD_WAIT;
            end
            OP_WRITE: begin
              ram_we = 1'b1;
              done_d = 1'b1;
            end
            OP_FILL: begin
              fill_data_d = cmd_data;
              cnt_d       = '0;
              state_d     = ST_FILL;
            end
            OP_SCAN: begin
              ram_addr = '0;
              cnt_d    = '0;
              state_d  = ST_SCAN_RD;
            end
            default: ;
          endcase
        end
      end

      ST_RD_WAIT: begin
        rd_valid_d = 1'b1;
        rd_addr_d  = cnt_q;
        rd_data_d  = ram_rdata;
        done_d     = 1'b1;
        state_d    = ST_IDLE;
      end

      ST_FILL: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          ram_we    = 1'b1;
          ram_addr  = cnt_q;
          ram_wdata = fill_data_q;
          if (cnt_q == LAST_ADDR) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      // The word for cnt is sitting in the RAM output register; emit it
      // unless aborted, which also discards it.
      ST_SCAN_RD: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          rd_valid_d = 1'b1;
          rd_addr_d  = cnt_q;
          rd_data_d  = ram_rdata;
          if (cnt_q == LAST_ADDR) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            timer_d = '0;
            state_d = ST_SCAN_WAIT;
          end
        end
      end

      // Pad so outputs land SCAN_PERIOD cycles apart; the last wait cycle
      // issues the read of the next address.
      ST_SCAN_WAIT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (timer_q == TIMER_LAST) begin
          ram_addr = cnt_q + 1'b1;
          cnt_d    = cnt_q + 1'b1;
          state_d  = ST_SCAN_RD;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // All controller state and outputs; memory contents live in ram_sp and
  // are untouched by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      timer_q     <= '0;
      fill_data_q <= '0;
      rd_valid_q  <= 1'b0;
      rd_addr_q   <= '0;
      rd_data_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      timer_q     <= timer_d;
      fill_data_q <= fill_data_d;
      rd_valid_q  <= rd_valid_d;
      rd_addr_q   <= rd_addr_d;
      rd_data_q   <= rd_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_addr  = rd_addr_q;
  assign rd_data  = rd_data_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_ram_fill_scan.sv
// Testbench for ram_fill_scan: a default-parameter instance exercised with
// directed and randomized commands, plus a DATA_W=8/ADDR_W=3/SCAN_PERIOD=2
// instance for the small-configuration fill and scan.
module tb_ram_fill_scan;

  localparam int DEPTH_A = 32;
  localparam int P_A     = 4;
  localparam int DEPTH_B = 8;
  localparam int P_B     = 2;

  localparam logic [1:0] OP_RD = 2'b00;
  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] OP_FL = 2'b10;
  localparam logic [1:0] OP_SC = 2'b11;

  logic       clock;
  logic       reset;

  logic       cmd_valid, cmd_ready, abort;
  logic [1:0] cmd_op;
  logic [4:0] cmd_addr;
  logic [3:0] cmd_data;
  logic       rd_valid, busy, done;
  logic [4:0] rd_addr;
  logic [3:0] rd_data;

  logic       cmd_valid_b, cmd_ready_b, abort_b;
  logic [1:0] cmd_op_b;
  logic [2:0] cmd_addr_b;
  logic [7:0] cmd_data_b;
  logic       rd_valid_b, busy_b, done_b;
  logic [2:0] rd_addr_b;
  logic [7:0] rd_data_b;

  int total = 0;
  int bad   = 0;

  logic [3:0] model_a [DEPTH_A];
  logic [7:0] model_b [DEPTH_B];

  ram_fill_scan dut_a (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .abort(abort),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done)
  );

  ram_fill_scan #(.DATA_W(8), .ADDR_W(3), .SCAN_PERIOD(2)) dut_b (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_op(cmd_op_b),
    .cmd_addr(cmd_addr_b), .cmd_data(cmd_data_b), .abort(abort_b),
    .rd_valid(rd_valid_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .busy(busy_b), .done(done_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Safety net so a stuck run still ends with a visible failure.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [4:0] addr,
                               input logic [3:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_data  = data;
  endtask

  task automatic writeA(input logic [4:0] addr, input logic [3:0] data);
    applyStimulus(OP_WR, addr, data);
    tick();
    cmd_valid = 1'b0;
    model_a[addr] = data;
    checkOutput("wr_done", 32'(done), 32'd1);
    checkOutput("wr_busy", 32'(busy), 32'd0);
    tick();
    checkOutput("wr_done_clr", 32'(done), 32'd0);
  endtask

  // READ with optional abort raised while the read is in flight; abort has
  // no effect on a READ.
  task automatic readA(input logic [4:0] addr, input bit with_abort);
    applyStimulus(OP_RD, addr, 4'($urandom));
    tick();
    cmd_valid = 1'b0;
    if (with_abort) abort = 1'b1;
    checkOutput("rd_busy", 32'(busy), 32'd1);
    checkOutput("rd_early", 32'(rd_valid), 32'd0);
    tick();
    checkOutput("rd_valid", 32'(rd_valid), 32'd1);
    checkOutput("rd_addr", 32'(rd_addr), 32'(addr));
    checkOutput("rd_data", 32'(rd_data), 32'(model_a[addr]));
    checkOutput("rd_done", 32'(done), 32'd1);
    abort = 1'b0;
    tick();
    checkOutput("rd_pulse_end", 32'(rd_valid), 32'd0);
    checkOutput("rd_idle", 32'(busy), 32'd0);
  endtask

  // FILL; stop_at>0 interrupts after that many write edges, by abort
  // (use_reset=0) or by reset (use_reset=1).
  task automatic fillA(input logic [3:0] value, input int stop_at, input bit use_reset);
    applyStimulus(OP_FL, 5'($urandom), value);
    tick();
    cmd_valid = 1'b0;
    cmd_data  = ~value;
    for (int n = 1; n <= DEPTH_A; n++) begin
      tick();
      checkOutput("fill_done", 32'(done), 32'(n == DEPTH_A));
      checkOutput("fill_busy", 32'(busy), 32'(n < DEPTH_A));
      if (n == stop_at) begin
        for (int a = 0; a < n; a++) model_a[a] = value;
        if (use_reset) begin
          reset = 1'b1;
          #1;
          checkOutput("rst_busy", 32'(busy), 32'd0);
          checkOutput("rst_done", 32'(done), 32'd0);
          checkOutput("rst_rdv", 32'(rd_valid), 32'd0);
          checkOutput("rst_rdaddr", 32'(rd_addr), 32'd0);
          checkOutput("rst_rddata", 32'(rd_data), 32'd0);
          tick();
          reset = 1'b0;
          #1;
          checkOutput("rst_ready", 32'(cmd_ready), 32'd1);
        end else begin
          abort = 1'b1;
          tick();
          checkOutput("fab_busy", 32'(busy), 32'd0);
          checkOutput("fab_done", 32'(done), 32'd0);
          abort = 1'b0;
          #1;
          checkOutput("fab_ready", 32'(cmd_ready), 32'd1);
        end
        return;
      end
    end
    for (int a = 0; a < DEPTH_A; a++) model_a[a] = value;
    tick();
    checkOutput("fill_done_clr", 32'(done), 32'd0);
  endtask

  // SCAN; abort_at>0 raises abort after that many edges past the accept.
  // Word k is expected 1+k*P_A edges after the accept edge.
  task automatic scanA(input int abort_at);
    int  last_n;
    int  k;
    bit  pulse;
    last_n = (DEPTH_A - 1) * P_A + 1;
    applyStimulus(OP_SC, 5'($urandom), 4'($urandom));
    tick();
    cmd_valid = 1'b0;
    checkOutput("scan_start_busy", 32'(busy), 32'd1);
    checkOutput("scan_start_rdv", 32'(rd_valid), 32'd0);
    for (int n = 1; n <= last_n + 2; n++) begin
      tick();
      k = (n - 1) / P_A;
      pulse = ((n - 1) % P_A == 0) && (k < DEPTH_A);
      checkOutput("scan_rdv", 32'(rd_valid), 32'(pulse));
      checkOutput("scan_done", 32'(done), 32'(n == last_n));
      checkOutput("scan_busy", 32'(busy), 32'(n < last_n));
      if (pulse) begin
        checkOutput("scan_addr", 32'(rd_addr), 32'(k));
        checkOutput("scan_data", 32'(rd_data), 32'(model_a[k]));
      end
      if (n == abort_at) begin
        abort = 1'b1;
        tick();
        checkOutput("sab_rdv", 32'(rd_valid), 32'd0);
        checkOutput("sab_done", 32'(done), 32'd0);
        checkOutput("sab_busy", 32'(busy), 32'd0);
        abort = 1'b0;
        #1;
        checkOutput("sab_ready", 32'(cmd_ready), 32'd1);
        for (int j = 0; j < P_A + 2; j++) begin
          tick();
          checkOutput("sab_quiet_rdv", 32'(rd_valid), 32'd0);
          checkOutput("sab_quiet_busy", 32'(busy), 32'd0);
        end
        return;
      end
    end
  endtask

  initial begin
    logic [4:0] a;
    logic [3:0] d;
    logic [7:0] vb;
    int         last_b;
    bit         pulse_b;

    reset = 1'b1;
    cmd_valid = 1'b0; cmd_op = OP_RD; cmd_addr = '0; cmd_data = '0; abort = 1'b0;
    cmd_valid_b = 1'b0; cmd_op_b = OP_RD; cmd_addr_b = '0; cmd_data_b = '0; abort_b = 1'b0;

    $display("[TB] reset values");
    tick();
    tick();
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_rdv", 32'(rd_valid), 32'd0);
    checkOutput("reset_rdaddr", 32'(rd_addr), 32'd0);
    checkOutput("reset_rddata", 32'(rd_data), 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("reset_ready", 32'(cmd_ready), 32'd1);
    checkOutput("reset_ready_b", 32'(cmd_ready_b), 32'd1);

    $display("[TB] write/read addr 5");
    writeA(5'd5, 4'hA);
    readA(5'd5, 1'b0);

    $display("[TB] random write/read");
    for (int i = 0; i < 6; i++) begin
      a = 5'($urandom);
      d = 4'($urandom);
      writeA(a, d);
      readA(a, 1'b0);
      readA(5'd5, (i % 2) == 1);
    end

    $display("[TB] fill 0x3 with command held");
    applyStimulus(OP_FL, 5'd0, 4'h3);
    tick();
    applyStimulus(OP_RD, 5'd7, 4'hE);
    for (int n = 1; n <= DEPTH_A; n++) begin
      tick();
      checkOutput("hold_ready", 32'(cmd_ready), 32'(n == DEPTH_A));
      checkOutput("hold_done", 32'(done), 32'(n == DEPTH_A));
      checkOutput("hold_busy", 32'(busy), 32'(n < DEPTH_A));
    end
    for (int i = 0; i < DEPTH_A; i++) model_a[i] = 4'h3;
    tick();
    cmd_valid = 1'b0;
    checkOutput("held_accept_busy", 32'(busy), 32'd1);
    checkOutput("held_accept_done", 32'(done), 32'd0);
    tick();
    checkOutput("held_rdv", 32'(rd_valid), 32'd1);
    checkOutput("held_addr", 32'(rd_addr), 32'd7);
    checkOutput("held_data", 32'(rd_data), 32'h3);
    tick();

    $display("[TB] full scan");
    scanA(0);

    $display("[TB] abort with valid in idle");
    a = 5'($urandom);
    abort = 1'b1;
    applyStimulus(OP_WR, a, ~model_a[a]);
    #1;
    checkOutput("idle_abort_ready", 32'(cmd_ready), 32'd0);
    tick();
    checkOutput("idle_abort_done", 32'(done), 32'd0);
    checkOutput("idle_abort_busy", 32'(busy), 32'd0);
    cmd_valid = 1'b0;
    abort = 1'b0;

    for (int i = 0; i < 4; i++) writeA(5'($urandom), 4'($urandom));

    $display("[TB] scan aborts");
    scanA(2 * P_A + 1);
    scanA(P_A * int'($urandom_range(20, 3)));

    $display("[TB] fill abort then scan");
    fillA(4'($urandom), int'($urandom_range(25, 5)), 1'b0);
    scanA(0);

    $display("[TB] reset during fill then scan");
    fillA(~model_a[10], 10, 1'b1);
    scanA(0);

    $display("[TB] small configuration fill and scan");
    vb = 8'($urandom);
    cmd_valid_b = 1'b1; cmd_op_b = OP_FL; cmd_data_b = vb;
    tick();
    cmd_valid_b = 1'b0; cmd_data_b = ~vb;
    for (int n = 1; n <= DEPTH_B; n++) begin
      tick();
      checkOutput("b_fill_done", 32'(done_b), 32'(n == DEPTH_B));
      checkOutput("b_fill_busy", 32'(busy_b), 32'(n < DEPTH_B));
    end
    for (int i = 0; i < DEPTH_B; i++) model_b[i] = vb;
    tick();
    cmd_valid_b = 1'b1; cmd_op_b = OP_SC; cmd_addr_b = 3'($urandom);
    tick();
    cmd_valid_b = 1'b0;
    last_b = (DEPTH_B - 1) * P_B + 1;
    for (int n = 1; n <= last_b + 2; n++) begin
      tick();
      pulse_b = ((n - 1) % P_B == 0) && ((n - 1) / P_B < DEPTH_B);
      checkOutput("b_scan_rdv", 32'(rd_valid_b), 32'(pulse_b));
      checkOutput("b_scan_done", 32'(done_b), 32'(n == last_b));
      if (pulse_b) begin
        checkOutput("b_scan_addr", 32'(rd_addr_b), 32'((n - 1) / P_B));
        checkOutput("b_scan_data", 32'(rd_data_b), 32'(model_b[(n - 1) / P_B]));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
